// File: rtl/fetch_queue.sv
// Fetch stage: PC -> imem word address, fetched {pc,instr} pushed into a DEPTH-entry FIFO; 1-cycle fetch-to-head, redirect clears FIFO.
// Stalls the PC when full and not popped; optional perf counters under FETCH_PERF_EN (ports tied to 0 otherwise).
module fetch_queue #(
  parameter int           N        = 64,
  parameter int           ADDR_W   = 6,
  parameter int           DEPTH    = 4,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_q,
  input  logic              br_valid,
  input  logic [N-1:0]      br_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [N-1:0]      out_pc,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed
);
  localparam int          PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [N-1:0]  pc_q, pc_d;
  logic [N-1:0]  pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push, pop;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign push      = !br_valid && ((count_q < FULL) || pop);
  assign imem_addr = pc_q[ADDR_W+1:2];
  assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : '0;

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (br_valid) begin
      // Redirect wins: any same-cycle pop is discarded along with the queue.
      pc_d     = {br_target[N-1:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + N'(4);
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + (PW+1)'(1);
      else if (pop && !push) count_d = count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]    <= pc_q;
        instr_mem_q[wr_ptr_q] <= imem_q;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, flushed_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_q + 32'(push);
      if (br_valid) flushed_q <= flushed_q + 32'(count_q);
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`else
  assign perf_fetched = 32'h0;
  assign perf_flushed = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed test-plan scenarios plus random redirect/ready traffic against a queue-based model.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic        br_valid;
  logic [63:0] br_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;

  fetch_queue dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_q(imem_q),
    .br_valid(br_valid), .br_target(br_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
  );

  always #5 clk = ~clk;

  logic [31:0] imem_mem [64];
  assign imem_q = imem_mem[imem_addr];

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  logic [63:0] m_pc;
  logic [31:0] m_fetched;
  logic [31:0] m_flushed;
  int          tests_run    = 0;
  int          tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("valid", 64'(out_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("head_instr", 64'(out_instr), 64'(m_q[0].instr));
      check("head_pc", out_pc, m_q[0].pc);
    end else begin
      check("idle_instr", 64'(out_instr), 64'h0);
      check("idle_pc", out_pc, 64'h0);
    end
    check("imem_addr", 64'(imem_addr), 64'(m_pc[7:2]));
`ifdef FETCH_PERF_EN
    check("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
    check("perf_flushed", 64'(perf_flushed), 64'(m_flushed));
`else
    check("perf_fetched", 64'(perf_fetched), 64'h0);
    check("perf_flushed", 64'(perf_flushed), 64'h0);
`endif
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc      = 64'h0;
    m_fetched = 32'h0;
    m_flushed = 32'h0;
  endtask

  // One clock: apply inputs, advance the model by the fetch rules, then compare.
  task automatic step(input logic br, input logic [63:0] tgt, input logic rdy);
    ent_t e;
    bit   pop;
    br_valid  = br;
    br_target = tgt;
    out_ready = rdy;
    pop = (m_q.size() > 0) && rdy;
    if (br) begin
      m_flushed += 32'(m_q.size());
      m_q.delete();
      m_pc = {tgt[63:2], 2'b00};
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_q.size() < 4) begin
        e.pc    = m_pc;
        e.instr = imem_mem[m_pc[7:2]];
        m_q.push_back(e);
        m_pc      += 64'd4;
        m_fetched += 32'd1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    br_valid  = 1'b0;
    br_target = 64'h0;
    out_ready = 1'b0;
    model_reset();
    #2;
    reset = 1'b1;
    #1;
    check_outputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    br_valid  = 1'b0;
    br_target = 64'h0;
    out_ready = 1'b0;
    for (int i = 0; i < 64; i++) imem_mem[i] = $urandom;
    imem_mem[0]  = 32'hf8000001;
    imem_mem[1]  = 32'hf8008002;
    imem_mem[30] = 32'hb4000040;
    imem_mem[62] = 32'h0;

    // Streaming from reset
    do_reset();
    check("rst_addr", 64'(imem_addr), 64'h0);
    step(1'b0, 64'h0, 1'b1);
    check("s1_instr0", 64'(out_instr), 64'hf8000001);
    check("s1_pc0", out_pc, 64'h0);
    step(1'b0, 64'h0, 1'b1);
    check("s1_instr1", 64'(out_instr), 64'hf8008002);
    check("s1_pc1", out_pc, 64'h4);
    repeat (4) step(1'b0, 64'h0, 1'b1);

    // Backpressure until full, then drain
    do_reset();
    repeat (6) step(1'b0, 64'h0, 1'b0);
    check("full_addr", 64'(imem_addr), 64'h4);
    check("full_head", 64'(out_instr), 64'hf8000001);
    repeat (8) step(1'b0, 64'h0, 1'b1);

    // Redirect with three entries queued
    do_reset();
    repeat (3) step(1'b0, 64'h0, 1'b0);
    step(1'b1, 64'h7A, 1'b0);
    check("br_valid0", 64'(out_valid), 64'h0);
    check("br_addr", 64'(imem_addr), 64'd30);
`ifdef FETCH_PERF_EN
    check("br_flushed", 64'(perf_flushed), 64'd3);
`else
    check("br_flushed", 64'(perf_flushed), 64'd0);
`endif
    step(1'b0, 64'h0, 1'b1);
    check("br_instr", 64'(out_instr), 64'hb4000040);
    check("br_pc", out_pc, 64'h78);

    // Redirect coincident with a pop
    repeat (3) step(1'b0, 64'h0, 1'b1);
    step(1'b1, 64'h40, 1'b1);
    step(1'b0, 64'h0, 1'b1);
    check("brpop_pc", out_pc, 64'h40);
    check("brpop_instr", 64'(out_instr), 64'(imem_mem[16]));

    // Asynchronous reset between edges
    repeat (2) step(1'b0, 64'h0, 1'b1);
    reset = 1'b0;
    #2;
    check("arst_valid", 64'(out_valid), 64'h0);
    check("arst_addr", 64'(imem_addr), 64'h0);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    step(1'b0, 64'h0, 1'b1);
    check("arst_instr0", 64'(out_instr), 64'hf8000001);
    check("arst_pc0", out_pc, 64'h0);

    // Address wrap past the top of imem
    step(1'b1, 64'hF8, 1'b1);
    step(1'b0, 64'h0, 1'b1);
    check("wrap_w62", 64'(out_instr), 64'h0);
    check("wrap_pc62", out_pc, 64'hF8);
    step(1'b0, 64'h0, 1'b1);
    check("wrap_addr", 64'(imem_addr), 64'h0);
    step(1'b0, 64'h0, 1'b1);
    check("wrap_pc", out_pc, 64'h100);
    check("wrap_instr", 64'(out_instr), 64'hf8000001);

    // Random redirect / backpressure traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) == 0), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch stage of the LEGv8 core, directly upstream of `imem`. It holds the program counter, drives the word address into `imem` and captures the combinational `imem` output each cycle. Each fetched word is pushed, paired with its PC, into a small FIFO that feeds decode through a valid/ready handshake. Branch redirects flush the FIFO and reload the PC.

## Interface
- `N`, 64, PC width in bits.
- `ADDR_W`, 6, `imem` word-address width.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `RESET_PC`, 0, PC value loaded on reset.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `imem_addr`  out  ADDR_W  word address to `imem`, equal to `pc[ADDR_W+1:2]`.
- `imem_q`  in  32  instruction word from `imem`, combinational from `imem_addr`.
- `br_valid`  in  1  redirect request, sampled at the rising edge.
- `br_target`  in  N  redirect PC.
- `out_valid`  out  1  FIFO head holds a valid entry.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  32  head instruction.
- `out_pc`  out  N  PC of the head instruction.
- `perf_fetched`  out  32  count of words pushed (see Configuration).
- `perf_flushed`  out  32  count of valid entries discarded by redirects.

## Operation
- State:
  - `pc` (N bits).
  - FIFO of DEPTH entries, each {pc, instr}.
  - Read and write pointers of `log2(DEPTH)` bits that wrap modulo DEPTH.
  - Occupancy count, 0..DEPTH.
- Pop = `out_valid && out_ready`.
- Push = `!br_valid && (count < DEPTH || pop)`.
- On push:
  - Write {pc, imem_q} at the write pointer.
  - `pc <= pc + 4`, wrapping modulo 2^N.
- When count = DEPTH and pop = 0: no push, `pc` holds, `imem_addr` holds.
- Full with a simultaneous pop: push and pop both occur and count is unchanged.
- Empty: push only, no pop possible; `out_instr` = 0 and `out_pc` = 0 while `out_valid` = 0.
- Redirect (`br_valid` = 1) has priority over both push and pop:
  - Count, read pointer and write pointer all clear to 0.
  - `pc <= {br_target[N-1:2], 2'b00}`; `br_target[1:0]` is ignored.
  - A pop in the same cycle is discarded and the consumer must not act on it.
  - `perf_flushed` increments by the count before the flush.
- The `imem` address wraps: PCs at or above 4·2^ADDR_W alias to low words. There is no range check.
- The head outputs come directly from the FIFO register; there is no combinational path from `imem_q` to `out_*`.

## Timing
- Reset values:
  - `pc` = RESET_PC, so `imem_addr` = RESET_PC[ADDR_W+1:2].
  - `out_valid` = 0, `out_instr` = 0, `out_pc` = 0.
  - `perf_*` = 0.
- Assertion of `reset` mid-operation clears everything asynchronously, with no clock required.
- First edge after reset release pushes word RESET_PC/4; `out_valid` = 1 in the following cycle.
- Fetch-to-output latency is 1 cycle.
- Sustained throughput is 1 instruction/cycle while `out_ready` = 1.
- Redirect penalty is 2 cycles:
  - Cycle after the redirect edge: `out_valid` = 0 and `imem_addr` = target word.
  - Next edge pushes the target; `out_valid` = 1 one cycle after that.
- `out_ready` may toggle freely. Head data is stable while `out_valid && !out_ready`, unless a redirect occurs.

## Configuration
- `FETCH_PERF_EN` defined:
  - `perf_fetched` increments by 1 on every push.
  - `perf_flushed` accumulates the flushed count.
  - Both counters wrap at 2^32.
- `FETCH_PERF_EN` undefined:
  - Counters are not synthesized.
  - Both `perf_*` ports are tied to 32'h0.
  - The port list is identical in both builds.

## Test plan
- Release reset with `RESET_PC` = 0 and `out_ready` = 1 against the program `imem`. Required:
  - Cycle 1: `out_instr` = f8000001, `out_pc` = 0.
  - Cycle 2: `out_instr` = f8008002, `out_pc` = 4.
  - `out_valid` stays 1 continuously.
- Hold `out_ready` = 0 for 6 cycles after reset. Required:
  - Count saturates at 4.
  - `imem_addr` holds at 4.
  - Head stays f8000001.
  - Raising `out_ready` then drains words 0..3 in order, with no gap before word 4.
- Assert `br_valid` with `br_target` = 0x7A while 3 entries are queued. Required:
  - Next cycle: `out_valid` = 0 and `imem_addr` = 30.
  - The cycle after: `out_instr` = b4000040, `out_pc` = 0x78.
  - `perf_flushed` = 3 with the macro defined, 0 without.
- Assert `br_valid` and a pop in the same cycle. Required:
  - The popped entry is flushed.
  - The next valid output is the target instruction only.
- Pull `reset` low between edges mid-stream. Required:
  - `out_valid` = 0 and `imem_addr` = 0 immediately, with no clock.
  - Restart matches the first scenario.
- Branch to 0xF8 (word 62) and run forward. Required:
  - Word 62 returns 0.
  - The PC after word 63 is 0x100, which maps to `imem_addr` = 0 (wrap).
  - `out_pc` = 0x100 with `out_instr` = f8000001.
